comparator_seq_ctrl: RTL and testbench

COMPARATOR_SEQ_CTRL -- requirements
Module: comparator_seq_ctrl

---
 rtl/comparator_seq_ctrl.sv | 160 ++++++++++++++++
 tb/tb_comparator_seq_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/comparator_seq_ctrl.sv
// comparator_seq_ctrl
//   Sequential magnitude comparator. Two MSB-bit operands are latched on
//   acceptance and compared CHUNK bits per cycle, starting at the most
//   significant slice and stopping at the first slice that differs.
//
//   Parameters:
//     MSB    operand width in bits
//     CHUNK  slice width compared per cycle (must divide MSB)
//
//   Ports:
//     clk, rst_n               clock, asynchronous active-low reset
//     start_valid/start_ready  request handshake; a/b sampled on acceptance
//     a, b                     operands
//     res_valid/res_ready      result handshake
//     greater, less, equal     registered result flags
//     busy                     high whenever not idle
//
//   Build option:
//     COMPARATOR_SEQ_SIGNED_EN  operands are two's complement; the top slice
//                               is compared signed, lower slices unsigned.
module comparator_seq_ctrl #(
    parameter int unsigned MSB   = 256,
    parameter int unsigned CHUNK = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start_valid,
    output logic           start_ready,
    input  logic [MSB-1:0] a,
    input  logic [MSB-1:0] b,
    output logic           res_valid,
    input  logic           res_ready,
    output logic           greater,
    output logic           less,
    output logic           equal,
    output logic           busy
);

    localparam int unsigned N    = MSB / CHUNK;
    localparam int unsigned IDXW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDXW-1:0] IDX_TOP = IDXW'(N - 1);

    typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

    state_t          state_q, state_d;
    logic [MSB-1:0]  a_q, a_d;
    logic [MSB-1:0]  b_q, b_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            greater_q, greater_d;
    logic            less_q, less_d;
    logic            equal_q, equal_d;
    logic            start_ready_q, start_ready_d;
    logic            res_valid_q, res_valid_d;
    logic            busy_q, busy_d;

    logic [CHUNK-1:0] slice_a, slice_b;
    logic             slice_gt, slice_lt;

    always_comb begin
        slice_a = a_q[idx_q*CHUNK +: CHUNK];
        slice_b = b_q[idx_q*CHUNK +: CHUNK];
`ifdef COMPARATOR_SEQ_SIGNED_EN
        // Only the top slice carries the sign bit.
        if (idx_q == IDX_TOP) begin
            slice_gt = $signed(slice_a) > $signed(slice_b);
            slice_lt = $signed(slice_a) < $signed(slice_b);
        end else begin
            slice_gt = slice_a > slice_b;
            slice_lt = slice_a < slice_b;
        end
`else
        slice_gt = slice_a > slice_b;
        slice_lt = slice_a < slice_b;
`endif
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        idx_d     = idx_q;
        greater_d = greater_q;
        less_d    = less_q;
        equal_d   = equal_q;

        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    a_d       = a;
                    b_d       = b;
                    idx_d     = IDX_TOP;
                    greater_d = 1'b0;
                    less_d    = 1'b0;
                    equal_d   = 1'b0;
                    state_d   = CMP;
                end
            end
            CMP: begin
                if (slice_gt) begin
                    greater_d = 1'b1;
                    state_d   = DONE;
                end else if (slice_lt) begin
                    less_d  = 1'b1;
                    state_d = DONE;
                end else if (idx_q == '0) begin
                    equal_d = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - IDXW'(1);
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Handshake outputs are registered from the next state so they
        // change together with the state register.
        start_ready_d = (state_d == IDLE);
        res_valid_d   = (state_d == DONE);
        busy_d        = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            a_q           <= '0;
            b_q           <= '0;
            idx_q         <= '0;
            greater_q     <= 1'b0;
            less_q        <= 1'b0;
            equal_q       <= 1'b0;
            start_ready_q <= 1'b1;
            res_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            a_q           <= a_d;
            b_q           <= b_d;
            idx_q         <= idx_d;
            greater_q     <= greater_d;
            less_q        <= less_d;
            equal_q       <= equal_d;
            start_ready_q <= start_ready_d;
            res_valid_q   <= res_valid_d;
            busy_q        <= busy_d;
        end
    end

    assign start_ready = start_ready_q;
    assign res_valid   = res_valid_q;
    assign greater     = greater_q;
    assign less        = less_q;
    assign equal       = equal_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_comparator_seq_ctrl.sv
// tb_comparator_seq_ctrl
//   Directed bench for comparator_seq_ctrl at MSB=256, CHUNK=32 (8 slices).
//   Expected flags and latencies are written by hand per vector.
module tb_comparator_seq_ctrl;

    localparam int unsigned MSB   = 256;
    localparam int unsigned CHUNK = 32;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           start_valid = 1'b0;
    logic           start_ready;
    logic [MSB-1:0] a = '0;
    logic [MSB-1:0] b = '0;
    logic           res_valid;
    logic           res_ready = 1'b0;
    logic           greater, less, equal, busy;

    int total = 0;
    int bad   = 0;

    comparator_seq_ctrl #(.MSB(MSB), .CHUNK(CHUNK)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .greater     (greater),
        .less        (less),
        .equal       (equal),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One full transaction. chg_at>0 overwrites a with all-ones that many
    // edges after acceptance; rr_early holds res_ready high from the start.
    task automatic run_cmp(input string name, input logic [MSB-1:0] av,
                           input logic [MSB-1:0] bv, input int eg, input int el,
                           input int ee, input int k, input int chg_at,
                           input bit rr_early);
        int cnt;
        @(negedge clk);
        a = av;
        b = bv;
        start_valid = 1'b1;
        if (rr_early) res_ready = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        chk({name, ".busy"}, int'(busy), 1);
        chk({name, ".start_ready"}, int'(start_ready), 0);
        cnt = 0;
        while (!res_valid && cnt < 20) begin
            @(posedge clk);
            #1;
            cnt++;
            if (cnt == chg_at) a = '1;
        end
        chk({name, ".latency"}, cnt, k);
        chk({name, ".greater"}, int'(greater), eg);
        chk({name, ".less"}, int'(less), el);
        chk({name, ".equal"}, int'(equal), ee);
        if (!rr_early) begin
            @(negedge clk);
            res_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        chk({name, ".idle_ready"}, int'(start_ready), 1);
        chk({name, ".idle_valid"}, int'(res_valid), 0);
        chk({name, ".flag_hold"}, int'({greater, less, equal}), (eg << 2) | (el << 1) | ee);
    endtask

    initial begin
        logic [MSB-1:0] av, bv;

        // Reset state
        #3 rst_n = 1'b0;
        #1;
        chk("rst.start_ready", int'(start_ready), 1);
        chk("rst.res_valid", int'(res_valid), 0);
        chk("rst.flags", int'({greater, less, equal}), 0);
        chk("rst.busy", int'(busy), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Top slice decides
        av = '0; av[255:252] = 4'hA;
        bv = '0; bv[255:252] = 4'hD;
        run_cmp("top_less", av, bv, 0, 1, 0, 1, 0, 1'b0);
        av = '0; av[255:252] = 4'hE;
        bv = '0; bv[255:252] = 4'hC;
        run_cmp("top_greater", av, bv, 1, 0, 0, 1, 0, 1'b0);

        // Full-length scans
        run_cmp("eq_zero", '0, '0, 0, 0, 1, 8, 0, 1'b0);
        run_cmp("bit0_greater", 256'h1, '0, 1, 0, 0, 8, 0, 1'b0);

        // Middle slices: bit 100 is in slice 3 -> k=5; bit 200 in slice 6 -> k=2
        run_cmp("mid_greater", 256'h1 << 100, '0, 1, 0, 0, 5, 0, 1'b0);
        run_cmp("mid_less", 256'h5 << 64, (256'h1 << 200) | (256'h5 << 64), 0, 1, 0, 2, 0, 1'b0);

        // Operand change after acceptance must not matter
        run_cmp("a_change", '0, '0, 0, 0, 1, 8, 2, 1'b0);

        // res_ready held high before DONE is ignored until DONE
        run_cmp("rr_early", 256'h7 << 40, 256'h9 << 40, 0, 1, 0, 7, 0, 1'b1);

        // Signed top slice
        av = '0; av[255:252] = 4'hE;
`ifdef COMPARATOR_SEQ_SIGNED_EN
        run_cmp("signed_top", av, 256'h1, 0, 1, 0, 1, 0, 1'b0);
`else
        run_cmp("unsigned_top", av, 256'h1, 1, 0, 0, 1, 0, 1'b0);
`endif

        // Stall in DONE while new requests are offered
        @(negedge clk);
        a = 256'h1;
        b = '0;
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("hold.reach_done", int'(res_valid), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start_valid = 1'b1;
            a = '0;
            b = '1;
            @(posedge clk);
            #1;
            chk("hold.res_valid", int'(res_valid), 1);
            chk("hold.flags", int'({greater, less, equal}), 4);
            chk("hold.start_ready", int'(start_ready), 0);
        end
        @(negedge clk);
        start_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        chk("hold.release_ready", int'(start_ready), 1);
        chk("hold.release_busy", int'(busy), 0);
        @(posedge clk);
        #1;
        chk("hold.no_queue", int'(busy), 0);
        chk("hold.flags_idle", int'({greater, less, equal}), 4);

        // Reset in the middle of a scan
        @(negedge clk);
        a = '0;
        b = '0;
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst.busy", int'(busy), 0);
        chk("midrst.start_ready", int'(start_ready), 1);
        chk("midrst.res_valid", int'(res_valid), 0);
        chk("midrst.flags", int'({greater, less, equal}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_cmp("after_rst", 256'h3 << 130, 256'h2 << 130, 1, 0, 0, 4, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
